// File: rtl/l2_ff_array_dp.sv
// Dual-port, byte-masked flop array for the L2 cache.
// Port 0 reads and writes; port 1 only writes (refills). Requests are staged for
// one cycle and commit at the following edge. A clear-sweep FSM zeroes every set,
// one per cycle, after reset and whenever flush is pulsed while idle.
module l2_ff_array_dp #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 32
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WIDTH/8-1:0]     wmask0,
  input  logic [S_INDEX-1:0]     addr0,
  input  logic [WIDTH-1:0]       din0,
  output logic [WIDTH-1:0]       dout0,
  input  logic                   csb1,
  input  logic [WIDTH/8-1:0]     wmask1,
  input  logic [S_INDEX-1:0]     addr1,
  input  logic [WIDTH-1:0]       din1,
  input  logic                   flush,
  output logic                   busy
);

  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int NBYTES   = WIDTH / 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SWEEP = 1'b1;

  localparam logic [S_INDEX-1:0] CNT_LAST = {S_INDEX{1'b1}};
  localparam logic [S_INDEX-1:0] CNT_ONE  = S_INDEX'(1);

  // Sweep FSM
  logic               state_q, state_d;
  logic [S_INDEX-1:0] cnt_q, cnt_d;

  // Port 0 stage
  logic               p0_vld_q, p0_vld_d;
  logic               p0_we_q, p0_we_d;
  logic [NBYTES-1:0]  p0_mask_q, p0_mask_d;
  logic [S_INDEX-1:0] addr0_q, addr0_d;
  logic [WIDTH-1:0]   p0_din_q, p0_din_d;

  // Port 1 stage
  logic               p1_vld_q, p1_vld_d;
  logic [NBYTES-1:0]  p1_mask_q, p1_mask_d;
  logic [S_INDEX-1:0] p1_addr_q, p1_addr_d;
  logic [WIDTH-1:0]   p1_din_q, p1_din_d;

  // Storage
  logic [WIDTH-1:0]   mem_q [NUM_SETS];
  logic [WIDTH-1:0]   mem_d [NUM_SETS];

  logic cap0, cap1;

  assign busy = (state_q == ST_SWEEP);

  // A flush edge behaves like a busy edge for capture: same-cycle requests are dropped.
  assign cap0 = !csb0 && !busy && !flush;
  assign cap1 = !csb1 && !busy && !flush;

  // Read data follows the stored address; blanked while the array is being cleared.
  assign dout0 = busy ? '0 : mem_q[addr0_q];

  // Sweep FSM: one set cleared per edge, flush ignored once a sweep is running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Request staging: valid bits are single-shot, payload holds when not capturing.
  always_comb begin
    p0_vld_d  = cap0;
    p0_we_d   = p0_we_q;
    p0_mask_d = p0_mask_q;
    addr0_d   = addr0_q;
    p0_din_d  = p0_din_q;
    p1_vld_d  = cap1;
    p1_mask_d = p1_mask_q;
    p1_addr_d = p1_addr_q;
    p1_din_d  = p1_din_q;
    if (cap0) begin
      p0_we_d   = !web0;
      p0_mask_d = wmask0;
      addr0_d   = addr0;
      p0_din_d  = din0;
    end
    if (cap1) begin
      p1_mask_d = wmask1;
      p1_addr_d = addr1;
      p1_din_d  = din1;
    end
  end

  // Array next state: port 1 bytes first so port 0 overrides on a shared byte;
  // the sweep clear never coincides with a staged commit but is applied last anyway.
  always_comb begin
    mem_d = mem_q;
    if (p1_vld_q) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (p1_mask_q[b]) begin
          mem_d[p1_addr_q][8*b +: 8] = p1_din_q[8*b +: 8];
        end
      end
    end
    if (p0_vld_q && p0_we_q) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (p0_mask_q[b]) begin
          mem_d[addr0_q][8*b +: 8] = p0_din_q[8*b +: 8];
        end
      end
    end
    if (state_q == ST_SWEEP) begin
      mem_d[cnt_q] = '0;
    end
  end

  // Control and stage registers; reset forces a fresh sweep from set 0.
  always_ff @(posedge clk0) begin
    if (!rst0) begin
      state_q  <= ST_SWEEP;
      cnt_q    <= '0;
      p0_vld_q <= 1'b0;
      p1_vld_q <= 1'b0;
      addr0_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p0_vld_q <= p0_vld_d;
      p1_vld_q <= p1_vld_d;
      addr0_q  <= addr0_d;
    end
  end

  // Payload registers need no reset; they are only consumed behind a valid bit.
  always_ff @(posedge clk0) begin
    p0_we_q   <= p0_we_d;
    p0_mask_q <= p0_mask_d;
    p0_din_q  <= p0_din_d;
    p1_mask_q <= p1_mask_d;
    p1_addr_q <= p1_addr_d;
    p1_din_q  <= p1_din_d;
  end

  // Array storage is frozen while reset is held; the sweep clears it afterwards.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_l2_ff_array_dp.sv
// Directed testbench for l2_ff_array_dp (S_INDEX=4, WIDTH=32).
module tb_l2_ff_array_dp;

  logic        clk0;
  logic        rst0;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [3:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        csb1;
  logic [3:0]  wmask1;
  logic [3:0]  addr1;
  logic [31:0] din1;
  logic        flush;
  logic        busy;

  int n_cmp;
  int n_err;
  int n_edges;

  l2_ff_array_dp #(.S_INDEX(4), .WIDTH(32)) dut (
    .clk0  (clk0),
    .rst0  (rst0),
    .csb0  (csb0),
    .web0  (web0),
    .wmask0(wmask0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (dout0),
    .csb1  (csb1),
    .wmask1(wmask1),
    .addr1 (addr1),
    .din1  (din1),
    .flush (flush),
    .busy  (busy)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  // Count edges until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wr0(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    tick();
    csb0 = 1'b1; web0 = 1'b1;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb1 = 1'b0; addr1 = a; din1 = d; wmask1 = m;
    tick();
    csb1 = 1'b1;
  endtask

  // Read request captured at one edge; dout0 checked in the following cycle.
  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
    tick();
    csb0 = 1'b1;
    chk(tag, dout0, exp);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; wmask1 = '0; addr1 = '0; din1 = '0; flush = 1'b0;

    // Reset sweep
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_dout", dout0, 32'h0);
    rst0 = 1'b1;
    wait_idle(n_edges);
    chk("rst_sweep_edges", n_edges, 32'd16);
    for (int s = 0; s < 16; s++) begin
      rd(4'(s), 32'h0, $sformatf("clear_set%0d", s));
    end

    // Byte-masked write with read-before-write
    wr0(4'd5, 32'hAABBCCDD, 4'hF);
    wr0(4'd5, 32'h11223344, 4'b0101);
    chk("rbw_old", dout0, 32'hAABBCCDD);
    tick();
    chk("rbw_new", dout0, 32'hAA22CC44);
    rd(4'd5, 32'hAA22CC44, "mask_rd5");

    // All-zero mask is a no-op
    wr0(4'd5, 32'h0, 4'b0000);
    tick();
    rd(4'd5, 32'hAA22CC44, "zero_mask");

    // Port 1 write to the tracked set: no forwarding
    wr1(4'd5, 32'h00000055, 4'b0001);
    chk("p1_before_commit", dout0, 32'hAA22CC44);
    tick();
    chk("p1_after_commit", dout0, 32'hAA22CC55);

    // Collision: merged masks, port 0 wins shared byte
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3; din0 = 32'h000000FF; wmask0 = 4'b0011;
    csb1 = 1'b0; addr1 = 4'd3; din1 = 32'hEEEEEEEE; wmask1 = 4'b1110;
    tick();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    tick();
    rd(4'd3, 32'hEEEE00FF, "collision_rd3");

    // Flush with a pending port 1 write and a dropped same-cycle port 0 write
    wr1(4'd7, 32'h12345678, 4'hF);
    flush = 1'b1;
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd8; din0 = 32'hFFFFFFFF; wmask0 = 4'hF;
    tick();
    flush = 1'b0; csb0 = 1'b1; web0 = 1'b1;
    chk("flush_busy", {31'b0, busy}, 32'd1);
    n_edges = 0;
    while (busy && n_edges < 100) begin
      if (n_edges == 2) chk("busy_dout_zero", dout0, 32'h0);
      if (n_edges == 3) flush = 1'b1;
      if (n_edges == 5) begin
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd2; din0 = 32'hFFFFFFFF; wmask0 = 4'hF;
      end
      tick();
      flush = 1'b0; csb0 = 1'b1; web0 = 1'b1;
      n_edges++;
    end
    chk("flush_sweep_edges", n_edges, 32'd16);
    rd(4'd7, 32'h0, "flush_rd7");
    rd(4'd8, 32'h0, "flush_rd8");
    rd(4'd2, 32'h0, "dropped_rd2");
    rd(4'd5, 32'h0, "flush_rd5");

    // Mid-sweep reset restarts the sweep
    wr0(4'd9, 32'hCAFEF00D, 4'hF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    rst0 = 1'b0;
    tick();
    chk("midrst_busy", {31'b0, busy}, 32'd1);
    rst0 = 1'b1;
    wait_idle(n_edges);
    chk("midrst_sweep_edges", n_edges, 32'd16);
    rd(4'd9, 32'h0, "midrst_rd9");
    rd(4'd3, 32'h0, "midrst_rd3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
